multicycle_controller: RTL and testbench

//  Sequencing FSM for the multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut regs).

---
 rtl/multicycle_controller.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath: decodes the IR opcode/func and
// drives all datapath selects and strobes, one instruction at a time.
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemToReg,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       WriteData_sel,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUoperation,
   output logic [1:0]       PCSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_IF, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_MEM_ADR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BR, S_JMP, S_JAL, S_JR
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_UNK = 3'b101;

   state_t state, next_state;
   logic   retire;

   function automatic logic [2:0] alu_from_func(input logic [5:0] f);
      case (f)
         6'b100000: alu_from_func = ALU_ADD;
         6'b100010: alu_from_func = ALU_SUB;
         6'b100100: alu_from_func = ALU_AND;
         6'b100101: alu_from_func = ALU_OR;
         6'b101010: alu_from_func = ALU_SLT;
         default:   alu_from_func = ALU_UNK;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IF;
         retired <= '0;
      end else begin
         state <= next_state;
         if (retire)
            retired <= retired + CNT_W'(1);
      end
   end

   // Everything stays at its default while rst_n is low, so strobes drop immediately
   always_comb begin
      next_state    = state;
      retire        = 1'b0;
      PCWrite       = 1'b0;
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemToReg      = 1'b0;
      RegWrite      = 1'b0;
      RegDst        = 2'b00;
      WriteData_sel = 2'b00;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUoperation  = 3'b000;
      PCSrc         = 2'b00;
      illegal       = 1'b0;
      if (rst_n) begin
         case (state)
            S_IF: begin
               MemRead      = 1'b1;
               ALUSrcB      = 2'b01;
               ALUoperation = ALU_ADD;
               if (mem_ready) begin
                  IRWrite    = 1'b1;
                  PCWrite    = 1'b1;
                  next_state = S_ID;
               end
            end
            S_ID: begin
               ALUSrcB      = 2'b11;
               ALUoperation = ALU_ADD;
               case (opcode)
                  OP_RTYPE:       next_state = (func == FN_JR) ? S_JR : S_EX_R;
                  OP_ADDI, OP_SLTI: next_state = S_EX_I;
                  OP_LW, OP_SW:   next_state = S_MEM_ADR;
                  OP_BEQ, OP_BNE: next_state = S_BR;
                  OP_J:           next_state = S_JMP;
                  OP_JAL:         next_state = S_JAL;
                  default: begin
                     illegal    = 1'b1;
                     next_state = S_IF;
                  end
               endcase
            end
            S_EX_R: begin
               ALUSrcA      = 1'b1;
               ALUoperation = alu_from_func(func);
               next_state   = S_WB_R;
            end
            S_WB_R: begin
               RegDst     = 2'b01;
               RegWrite   = 1'b1;
               retire     = 1'b1;
               next_state = S_IF;
            end
            S_EX_I: begin
               ALUSrcA      = 1'b1;
               ALUSrcB      = 2'b10;
               ALUoperation = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
               next_state   = S_WB_I;
            end
            S_WB_I: begin
               RegWrite   = 1'b1;
               retire     = 1'b1;
               next_state = S_IF;
            end
            S_MEM_ADR: begin
               ALUSrcA      = 1'b1;
               ALUSrcB      = 2'b10;
               ALUoperation = ALU_ADD;
               next_state   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
               if (mem_ready)
                  next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
               MemToReg   = 1'b1;
               RegWrite   = 1'b1;
               retire     = 1'b1;
               next_state = S_IF;
            end
            S_MEM_WR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
               if (mem_ready) begin
                  retire     = 1'b1;
                  next_state = S_IF;
               end
            end
            S_BR: begin
               ALUSrcA      = 1'b1;
               ALUoperation = ALU_SUB;
               PCSrc        = 2'b01;
               PCWrite      = (opcode == OP_BNE) ? ~Zero : Zero;
               retire       = 1'b1;
               next_state   = S_IF;
            end
            S_JMP: begin
               PCSrc      = 2'b10;
               PCWrite    = 1'b1;
               retire     = 1'b1;
               next_state = S_IF;
            end
            S_JAL: begin
               PCSrc         = 2'b10;
               PCWrite       = 1'b1;
               RegDst        = 2'b10;
               WriteData_sel = 2'b01;
               RegWrite      = 1'b1;
               retire        = 1'b1;
               next_state    = S_IF;
            end
            S_JR: begin
               PCSrc      = 2'b11;
               PCWrite    = 1'b1;
               retire     = 1'b1;
               next_state = S_IF;
            end
            default: next_state = S_IF;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected control words are queued as each
// cycle is driven and popped for comparison at the following falling edge.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        Zero;
   logic        mem_ready;
   logic        PCWrite, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegWrite;
   logic [1:0]  RegDst, WriteData_sel, ALUSrcB, PCSrc;
   logic        ALUSrcA, illegal;
   logic [2:0]  ALUoperation;
   logic [31:0] retired;

   logic [19:0] obs;
   logic [19:0] sbQueue[$];
   int          checks = 0;
   int          errors = 0;
   int          expRetired = 0;

   multicycle_controller #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .Zero(Zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
      .RegWrite(RegWrite), .RegDst(RegDst), .WriteData_sel(WriteData_sel),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUoperation(ALUoperation),
      .PCSrc(PCSrc), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   assign obs = {PCWrite, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegWrite,
                 RegDst, WriteData_sel, ALUSrcA, ALUSrcB, ALUoperation, PCSrc, illegal};

   function automatic logic [19:0] mk(input logic pcw, iord, irw, mr, mw, m2r, rw,
                                      input logic [1:0] rd, wd, input logic asa,
                                      input logic [1:0] asb, input logic [2:0] aop,
                                      input logic [1:0] pcs, input logic ill);
      mk = {pcw, iord, irw, mr, mw, m2r, rw, rd, wd, asa, asb, aop, pcs, ill};
   endfunction

   function automatic logic [19:0] eIF(input logic rdy);
      eIF = mk(rdy,0,rdy,1,0,0,0,2'b00,2'b00,0,2'b01,3'b010,2'b00,0);
   endfunction
   function automatic logic [19:0] eID(input logic ill);
      eID = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b010,2'b00,ill);
   endfunction
   function automatic logic [19:0] eEXR(input logic [2:0] aop);
      eEXR = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b00,aop,2'b00,0);
   endfunction
   function automatic logic [19:0] eEXI(input logic [2:0] aop);
      eEXI = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,aop,2'b00,0);
   endfunction
   function automatic logic [19:0] eBR(input logic p);
      eBR = mk(p,0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b110,2'b01,0);
   endfunction

   localparam logic [19:0] E_WBR  = {7'b0000001, 2'b01, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
   localparam logic [19:0] E_WBI  = {7'b0000001, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
   localparam logic [19:0] E_MRD  = {7'b0101000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
   localparam logic [19:0] E_MWB  = {7'b0000011, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
   localparam logic [19:0] E_MWR  = {7'b0100100, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
   localparam logic [19:0] E_JMP  = {7'b1000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0};
   localparam logic [19:0] E_JAL  = {7'b1000001, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0};
   localparam logic [19:0] E_JR   = {7'b1000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b11, 1'b0};
   localparam logic [19:0] E_ZERO = 20'h0;

   // Pops the oldest expected control word and compares it with the live outputs
   task automatic checkOutput(input string tag);
      logic [19:0] expWord;
      checks++;
      if (sbQueue.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s scoreboard empty, observed %h", tag, obs);
      end else begin
         expWord = sbQueue.pop_front();
         assert (obs === expWord) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, expWord);
         end
      end
   endtask

   task automatic checkRetired(input string tag);
      checks++;
      assert (retired === 32'(expRetired)) else begin
         errors++;
         $error("[TB] FAIL %s retired observed %0d expected %0d", tag, retired, expRetired);
      end
   endtask

   // Drives one cycle of inputs, queues its expected outputs, checks at the falling edge
   task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic rdy, input logic [19:0] expWord);
      opcode    = op;
      func      = fn;
      Zero      = z;
      mem_ready = rdy;
      sbQueue.push_back(expWord);
      @(negedge clk);
      checkOutput(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; opcode = '0; func = '0; Zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sbQueue.push_back(E_ZERO);
      checkOutput("reset_outputs");
      checkRetired("reset_retired");
      rst_n = 1'b1;

      applyStimulus("add_if",  6'h00, 6'b100000, 0, 1, eIF(1));
      applyStimulus("add_id",  6'h00, 6'b100000, 0, 1, eID(0));
      applyStimulus("add_ex",  6'h00, 6'b100000, 0, 1, eEXR(3'b010));
      applyStimulus("add_wb",  6'h00, 6'b100000, 0, 1, E_WBR);
      expRetired++; checkRetired("add_retired");

      applyStimulus("lw_if",   6'b100011, 6'h00, 0, 1, eIF(1));
      applyStimulus("lw_id",   6'b100011, 6'h00, 0, 1, eID(0));
      applyStimulus("lw_adr",  6'b100011, 6'h00, 0, 1, eEXI(3'b010));
      applyStimulus("lw_rd0",  6'b100011, 6'h00, 0, 0, E_MRD);
      applyStimulus("lw_rd1",  6'b100011, 6'h00, 0, 0, E_MRD);
      applyStimulus("lw_rd2",  6'b100011, 6'h00, 0, 1, E_MRD);
      applyStimulus("lw_wb",   6'b100011, 6'h00, 0, 1, E_MWB);
      expRetired++; checkRetired("lw_retired");

      applyStimulus("beq_if",  6'b000100, 6'h00, 1, 1, eIF(1));
      applyStimulus("beq_id",  6'b000100, 6'h00, 1, 1, eID(0));
      applyStimulus("beq_br",  6'b000100, 6'h00, 1, 1, eBR(1));
      expRetired++; checkRetired("beq_retired");

      applyStimulus("bne_ifw", 6'b000101, 6'h00, 1, 0, eIF(0));
      applyStimulus("bne_if",  6'b000101, 6'h00, 1, 1, eIF(1));
      applyStimulus("bne_id",  6'b000101, 6'h00, 1, 1, eID(0));
      applyStimulus("bne_br",  6'b000101, 6'h00, 1, 1, eBR(0));
      expRetired++; checkRetired("bne_retired");

      applyStimulus("jal_if",  6'b000011, 6'h00, 0, 1, eIF(1));
      applyStimulus("jal_id",  6'b000011, 6'h00, 0, 1, eID(0));
      applyStimulus("jal_ex",  6'b000011, 6'h00, 0, 1, E_JAL);
      applyStimulus("jr_if",   6'h00, 6'b001000, 0, 1, eIF(1));
      applyStimulus("jr_id",   6'h00, 6'b001000, 0, 1, eID(0));
      applyStimulus("jr_ex",   6'h00, 6'b001000, 0, 1, E_JR);
      applyStimulus("j_if",    6'b000010, 6'h00, 0, 1, eIF(1));
      applyStimulus("j_id",    6'b000010, 6'h00, 0, 1, eID(0));
      applyStimulus("j_ex",    6'b000010, 6'h00, 0, 1, E_JMP);
      expRetired += 3; checkRetired("jump_retired");

      applyStimulus("sub_if",  6'h00, 6'b100010, 0, 1, eIF(1));
      applyStimulus("sub_id",  6'h00, 6'b100010, 0, 1, eID(0));
      applyStimulus("sub_ex",  6'h00, 6'b100010, 0, 1, eEXR(3'b110));
      applyStimulus("sub_wb",  6'h00, 6'b100010, 0, 1, E_WBR);
      applyStimulus("slt_if",  6'h00, 6'b101010, 0, 1, eIF(1));
      applyStimulus("slt_id",  6'h00, 6'b101010, 0, 1, eID(0));
      applyStimulus("slt_ex",  6'h00, 6'b101010, 0, 1, eEXR(3'b111));
      applyStimulus("slt_wb",  6'h00, 6'b101010, 0, 1, E_WBR);
      applyStimulus("or_if",   6'h00, 6'b100101, 0, 1, eIF(1));
      applyStimulus("or_id",   6'h00, 6'b100101, 0, 1, eID(0));
      applyStimulus("or_ex",   6'h00, 6'b100101, 0, 1, eEXR(3'b001));
      applyStimulus("or_wb",   6'h00, 6'b100101, 0, 1, E_WBR);
      applyStimulus("unk_if",  6'h00, 6'b111111, 0, 1, eIF(1));
      applyStimulus("unk_id",  6'h00, 6'b111111, 0, 1, eID(0));
      applyStimulus("unk_ex",  6'h00, 6'b111111, 0, 1, eEXR(3'b101));
      applyStimulus("unk_wb",  6'h00, 6'b111111, 0, 1, E_WBR);
      expRetired += 4; checkRetired("rtype_retired");

      applyStimulus("addi_if", 6'b001000, 6'h00, 0, 1, eIF(1));
      applyStimulus("addi_id", 6'b001000, 6'h00, 0, 1, eID(0));
      applyStimulus("addi_ex", 6'b001000, 6'h00, 0, 1, eEXI(3'b010));
      applyStimulus("addi_wb", 6'b001000, 6'h00, 0, 1, E_WBI);
      applyStimulus("slti_if", 6'b001010, 6'h00, 0, 1, eIF(1));
      applyStimulus("slti_id", 6'b001010, 6'h00, 0, 1, eID(0));
      applyStimulus("slti_ex", 6'b001010, 6'h00, 0, 1, eEXI(3'b111));
      applyStimulus("slti_wb", 6'b001010, 6'h00, 0, 1, E_WBI);
      applyStimulus("sw_if",   6'b101011, 6'h00, 0, 1, eIF(1));
      applyStimulus("sw_id",   6'b101011, 6'h00, 0, 1, eID(0));
      applyStimulus("sw_adr",  6'b101011, 6'h00, 0, 1, eEXI(3'b010));
      applyStimulus("sw_wr",   6'b101011, 6'h00, 0, 1, E_MWR);
      expRetired += 3; checkRetired("imm_sw_retired");

      applyStimulus("ill_if",  6'b111111, 6'h00, 0, 1, eIF(1));
      applyStimulus("ill_id",  6'b111111, 6'h00, 0, 1, eID(1));
      applyStimulus("ill_next",6'b111111, 6'h00, 0, 0, eIF(0));
      checkRetired("ill_retired");

      applyStimulus("rsw_if",  6'b101011, 6'h00, 0, 1, eIF(1));
      applyStimulus("rsw_id",  6'b101011, 6'h00, 0, 1, eID(0));
      applyStimulus("rsw_adr", 6'b101011, 6'h00, 0, 1, eEXI(3'b010));
      applyStimulus("rsw_wr",  6'b101011, 6'h00, 0, 0, E_MWR);
      rst_n = 1'b0;
      #1;
      sbQueue.push_back(E_ZERO);
      checkOutput("midreset_outputs");
      expRetired = 0;
      checkRetired("midreset_retired");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus("post_ifw", 6'h00, 6'b100100, 0, 0, eIF(0));
      applyStimulus("post_if",  6'h00, 6'b100100, 0, 1, eIF(1));
      applyStimulus("post_id",  6'h00, 6'b100100, 0, 1, eID(0));
      applyStimulus("post_ex",  6'h00, 6'b100100, 0, 1, eEXR(3'b000));
      applyStimulus("post_wb",  6'h00, 6'b100100, 0, 1, E_WBR);
      expRetired++; checkRetired("post_retired");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
